// File: rtl/core_pkg.sv
// Shared core types and constants: IF/ID payload and fetch-stage defaults.
package core_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
    logic            misalign;
  } if_id_t;

  // Empty IF/ID slot carrying the canonical NOP.
  function automatic if_id_t if_id_bubble();
    if_id_t b;
    b.valid    = 1'b0;
    b.pc       = '0;
    b.pc_plus4 = '0;
    b.instr    = NOP_INSTR;
    b.misalign = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/pc_gen.sv
// Program counter with next-PC selection (advance / hold / aligned redirect)
// and the sticky misalign flag for the first instruction after a redirect.
module pc_gen #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]  RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_i,
  input  logic                  redirect_valid_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic                  misalign_o
);

  logic [DATA_WIDTH-1:0] r_pc;
  logic                  r_misalign;
  logic [DATA_WIDTH-1:0] w_pc_nxt;
  logic                  w_misalign_nxt;

  // Redirect outranks the load-use hold.
  always_comb begin
    w_pc_nxt       = r_pc;
    w_misalign_nxt = r_misalign;
    if (redirect_valid_i) begin
      w_pc_nxt       = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
      w_misalign_nxt = |redirect_pc_i[1:0];
    end else if (!stall_i) begin
      w_pc_nxt       = r_pc + DATA_WIDTH'(4);
      w_misalign_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

  assign pc_o       = r_pc;
  assign misalign_o = r_misalign;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives instr_mem with the PC and captures the
// returned word into the IF/ID register, honouring stall, flush and redirect.
module fetch_stage
  import core_pkg::if_id_t;
  import core_pkg::if_id_bubble;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = core_pkg::RESET_PC,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = core_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  redirect_valid_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_instr_i,
  output logic                  if_id_valid_o,
  output logic [DATA_WIDTH-1:0] if_id_pc_o,
  output logic [DATA_WIDTH-1:0] if_id_pc_plus4_o,
  output logic [DATA_WIDTH-1:0] if_id_instr_o,
  output logic                  if_id_misalign_o
);

  logic [DATA_WIDTH-1:0] w_pc;
  logic                  w_misalign;
  if_id_t                r_if_id;
  if_id_t                w_if_id_nxt;
  if_id_t                w_bubble;

  pc_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_gen (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .pc_o             (w_pc),
    .misalign_o       (w_misalign)
  );

  always_comb begin
    w_bubble       = if_id_bubble();
    w_bubble.instr = NOP_INSTR;
  end

  // Wrong-path word is dropped on redirect; flush squashes even while stalled.
  always_comb begin
    w_if_id_nxt = r_if_id;
    if (redirect_valid_i) begin
      w_if_id_nxt = w_bubble;
    end else if (stall_i) begin
      if (flush_i) w_if_id_nxt = w_bubble;
    end else if (flush_i) begin
      w_if_id_nxt = w_bubble;
    end else begin
      w_if_id_nxt.valid    = 1'b1;
      w_if_id_nxt.pc       = w_pc;
      w_if_id_nxt.pc_plus4 = w_pc + DATA_WIDTH'(4);
      w_if_id_nxt.instr    = imem_instr_i;
      w_if_id_nxt.misalign = w_misalign;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_if_id <= w_bubble;
    else        r_if_id <= w_if_id_nxt;
  end

  assign imem_addr_o      = w_pc;
  assign if_id_valid_o    = r_if_id.valid;
  assign if_id_pc_o       = r_if_id.pc;
  assign if_id_pc_plus4_o = r_if_id.pc_plus4;
  assign if_id_instr_o    = r_if_id.instr;
  assign if_id_misalign_o = r_if_id.misalign;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: behavioural IF model checked every
// cycle, plus hand-computed expectations along a directed program walk.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        flush_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic        if_id_valid_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_pc_plus4_o;
  logic [31:0] if_id_instr_o;
  logic        if_id_misalign_o;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_addr_o      (imem_addr_o),
    .imem_instr_i     (imem_instr_i),
    .if_id_valid_o    (if_id_valid_o),
    .if_id_pc_o       (if_id_pc_o),
    .if_id_pc_plus4_o (if_id_pc_plus4_o),
    .if_id_instr_o    (if_id_instr_o),
    .if_id_misalign_o (if_id_misalign_o)
  );

  // Instruction memory contents: two fixed words, the rest address-tagged.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0013;
      32'h0000_0004: return 32'h0010_0093;
      default:       return 32'hA500_0000 ^ a;
    endcase
  endfunction

  assign imem_instr_i = mem_word(imem_addr_o);

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: PC, pending misalign tag, and the IF/ID slot contents.
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
  logic        m_flag, m_valid, m_mis;

  task automatic m_bubble();
    m_valid = 1'b0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_instr = NOP; m_mis = 1'b0;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_bubble();
      m_pc   = 32'h0;
      m_flag = 1'b0;
    end else if (redirect_valid_i) begin
      m_bubble();
      m_pc   = redirect_pc_i & ~32'd3;
      m_flag = (redirect_pc_i % 4) != 0;
    end else if (stall_i) begin
      if (flush_i) m_bubble();
    end else begin
      if (flush_i) m_bubble();
      else begin
        m_valid = 1'b1; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
        m_instr = mem_word(m_pc); m_mis = m_flag;
      end
      m_pc   = m_pc + 32'd4;
      m_flag = 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_addr",     imem_addr_o,              m_pc);
      check("m_valid",    32'(if_id_valid_o),       32'(m_valid));
      check("m_pc",       if_id_pc_o,               m_ipc);
      check("m_pc4",      if_id_pc_plus4_o,         m_ipc4);
      check("m_instr",    if_id_instr_o,            m_instr);
      check("m_misalign", 32'(if_id_misalign_o),    32'(m_mis));
    end
  end

  task automatic drive(input logic st, input logic fl, input logic rv,
                       input logic [31:0] rpc, input logic rn);
    stall_i = st; flush_i = fl; redirect_valid_i = rv; redirect_pc_i = rpc; rst_n = rn;
    @(posedge clk);
    #2;
  endtask

  task automatic step(); drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1); endtask

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    redirect_valid_i = 1'b0; redirect_pc_i = 32'h0;

    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk_en = 1'b1;
    check("rst_valid", 32'(if_id_valid_o), 32'd0);
    check("rst_instr", if_id_instr_o, NOP);
    check("rst_addr",  imem_addr_o, 32'h0);

    step();
    check("seq0_pc",    if_id_pc_o, 32'h0);
    check("seq0_instr", if_id_instr_o, 32'h0000_0013);
    check("seq0_valid", 32'(if_id_valid_o), 32'd1);
    step();
    check("seq1_pc",    if_id_pc_o, 32'h4);
    check("seq1_instr", if_id_instr_o, 32'h0010_0093);
    check("seq1_pc4",   if_id_pc_plus4_o, 32'h8);

    repeat (13) step();
    check("pre_stall_addr", imem_addr_o, 32'h3C);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check("stall_pc",    if_id_pc_o, 32'h38);
    check("stall_instr", if_id_instr_o, 32'hA500_0038);
    check("stall_addr",  imem_addr_o, 32'h3C);
    step();
    check("resume_pc",   if_id_pc_o, 32'h3C);

    repeat (8) step();
    check("pre_br_addr", imem_addr_o, 32'h60);
    drive(1'b0, 1'b0, 1'b1, 32'h48, 1'b1);
    check("br_valid", 32'(if_id_valid_o), 32'd0);
    check("br_instr", if_id_instr_o, NOP);
    step();
    check("br_tgt_pc",    if_id_pc_o, 32'h48);
    check("br_tgt_valid", 32'(if_id_valid_o), 32'd1);

    drive(1'b1, 1'b0, 1'b1, 32'h70, 1'b1);
    check("rs_addr",  imem_addr_o, 32'h70);
    check("rs_valid", 32'(if_id_valid_o), 32'd0);
    step();

    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    check("fl_valid", 32'(if_id_valid_o), 32'd0);
    check("fl_addr",  imem_addr_o, 32'h78);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    check("fls_addr", imem_addr_o, 32'h78);
    step();
    check("fl_next_pc", if_id_pc_o, 32'h78);

    drive(1'b0, 1'b0, 1'b1, 32'h01, 1'b1);
    check("mis_addr", imem_addr_o, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step();
    check("mis_set", 32'(if_id_misalign_o), 32'd1);
    check("mis_pc",  if_id_pc_o, 32'h0);
    step();
    check("mis_clr", 32'(if_id_misalign_o), 32'd0);

    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    step();
    check("wrap_pc",   if_id_pc_o, 32'hFFFF_FFFC);
    check("wrap_pc4",  if_id_pc_plus4_o, 32'h0);
    check("wrap_addr", imem_addr_o, 32'h0);
    check("wrap_mis",  32'(if_id_misalign_o), 32'd0);
    step();

    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("mrst_addr",  imem_addr_o, 32'h0);
    check("mrst_valid", 32'(if_id_valid_o), 32'd0);
    check("mrst_pc",    if_id_pc_o, 32'h0);
    check("mrst_pc4",   if_id_pc_plus4_o, 32'h0);
    check("mrst_instr", if_id_instr_o, NOP);
    check("mrst_mis",   32'(if_id_misalign_o), 32'd0);

    for (int i = 0; i < 60; i++) begin
      drive(($urandom % 4) == 0, ($urandom % 5) == 0, ($urandom % 7) == 0,
            $urandom_range(0, 255), 1'b1);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
